// File: rtl/fir_rate_pkg.sv
// fir_rate_pkg: shared types and elaboration-time helpers for the FIR rate scheduler.
package fir_rate_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int acc_width(input int freq_in);
    return $clog2(freq_in) + 1;
  endfunction
  function automatic bit ratio_ok(input int freq_in, input int freq_out);
    return freq_out > 0 && freq_out <= freq_in;
  endfunction
  function automatic bit depth_ok(input int depth);
    return depth >= 2 && (depth & (depth - 1)) == 0;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy counter; caller guards push/pop with full/empty.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr, rd;
  logic [PW:0] count;
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/fir_rate_sched.sv
// fir_rate_sched: Bresenham-paced launch scheduler feeding a FIR from a small input FIFO.
module fir_rate_sched
  import fir_rate_pkg::*;
#(
  parameter int FREQ_IN = 12,
  parameter int FREQ_OUT = 10,
  parameter int DATA_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              inValid,
  input  logic [DATA_W-1:0] inData,
  output logic              inReady,
  output logic              firStart,
  output logic [DATA_W-1:0] firData,
  input  logic              firDone,
  output logic              tick,
  output logic              underflow,
  output logic              overrun,
  input  logic              clrFlags
);
  localparam int AW = acc_width(FREQ_IN);
  if (!ratio_ok(FREQ_IN, FREQ_OUT)) begin : g_bad_ratio
    $error("FREQ_OUT must satisfy 0 < FREQ_OUT <= FREQ_IN");
  end
  if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  state_t state, state_nx;
  logic [AW-1:0] acc, acc_sum;
  logic [DATA_W-1:0] head;
  logic pending, avail, slot, launch, push, full, empty;
  assign acc_sum = acc + AW'(FREQ_OUT);
  assign tick = acc_sum >= AW'(FREQ_IN);
  // a firDone cycle is treated as idle so back-to-back launches need only one gap cycle
  assign avail = state == IDLE || firDone;
  assign slot = avail && (pending || tick);
  assign launch = slot && !empty;
  assign push = inValid && !full;
  assign inReady = !full;
  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(resetN),
    .push(push),
    .pop(launch),
    .din(inData),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb state_nx = launch ? BUSY : avail ? IDLE : state;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      acc <= '0;
      pending <= 1'b0;
      firStart <= 1'b0;
      firData <= '0;
      underflow <= 1'b0;
      overrun <= 1'b0;
    end else begin
      acc <= tick ? acc_sum - AW'(FREQ_IN) : acc_sum;
      pending <= slot ? pending && tick : pending || tick;
      firStart <= launch;
      if (launch) firData <= head;
      underflow <= (slot && empty) || (underflow && !clrFlags);
      overrun <= (tick && pending && !slot) || (overrun && !clrFlags);
    end
endmodule

// File: tb/tb_fir_rate_sched.sv
// tb_fir_rate_sched: random-stimulus scoreboard bench with a closed-form tick model and a FIR responder.
module tb_fir_rate_sched;
  localparam int FI = 12;
  localparam int FO = 10;
  localparam int DW = 16;
  logic clk = 0;
  logic resetN, inValid, inReady, firStart, firDone, tick, underflow, overrun, clrFlags;
  logic [DW-1:0] inData, firData;
  int checks = 0, errors = 0;
  int k = 0, cyc = 0, tick_cnt = 0, launches = 0;
  bit fir_busy = 0, fir_hold = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] got[$];
  int launch_t[$];

  fir_rate_sched #(.FREQ_IN(FI), .FREQ_OUT(FO), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inData(inData), .inReady(inReady),
    .firStart(firStart), .firData(firData), .firDone(firDone), .tick(tick),
    .underflow(underflow), .overrun(overrun), .clrFlags(clrFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_tick(input int n);
    return ((n + 1) * FO) / FI != (n * FO) / FI;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    inValid = v;
    inData = d;
    if (v && inReady) q.push_back(d);
  endtask

  task automatic wait_launches(input int n, input int budget);
    int b = 0;
    while (launches < n && b < budget) begin
      step();
      b++;
    end
    chk("launch_wait", launches >= n, 1);
  endtask

  // tick reference: the n-th cycle after reset carries a slot when floor(n*FO/FI) steps up
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!resetN) k = 0;
    else begin
      chk("tick", tick, model_tick(k));
      if (k < 120 && tick) tick_cnt++;
      k++;
    end
  end

  // FIR responder (one-cycle turnaround unless held) plus scoreboard monitor
  initial begin
    firDone = 0;
    forever begin
      @(negedge clk);
      firDone = 0;
      if (!resetN) fir_busy = 0;
      else begin
        if (fir_busy && !fir_hold) begin
          firDone = 1;
          fir_busy = 0;
        end
        if (firStart) begin
          launches++;
          launch_t.push_back(cyc);
          got.push_back(firData);
          chk("start_while_busy", fir_busy, 0);
          chk("launch_expected", q.size() != 0, 1);
          if (q.size() != 0) chk("fir_data", firData, q.pop_front());
          fir_busy = 1;
        end
      end
    end
  end

  initial begin
    int n0, s0;
    resetN = 1; inValid = 0; inData = 0; clrFlags = 0;
    #1 resetN = 0;
    #2;
    chk("rst_in_ready", inReady, 1);
    chk("rst_fir_start", firStart, 0);
    chk("rst_fir_data", firData, 0);
    chk("rst_tick", tick, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_overrun", overrun, 0);
    repeat (2) @(posedge clk);
    #2 resetN = 1;

    while (k < 120) step();
    chk("ticks_per_120", tick_cnt, 100);
    chk("underflow_idle", underflow, 1);
    chk("overrun_idle", overrun, 0);
    while (model_tick(k)) step();
    clrFlags = 1;
    step();
    clrFlags = 0;
    #3 chk("underflow_clr", underflow, 0);

    s0 = launch_t.size();
    for (int i = 0; i < 40; i++) begin
      drive(1, DW'($urandom));
      clrFlags = i == 4;
      step();
    end
    clrFlags = 0;
    #3 chk("underflow_stream", underflow, 0);
    drive(0, 0);
    for (int b = 0; b < 100 && q.size() != 0; b++) step();
    chk("stream_drained", q.size(), 0);
    for (int i = s0 + 1; i < launch_t.size(); i++)
      chk("launch_gap", launch_t[i] - launch_t[i-1], 2);
    repeat (4) step();

    clrFlags = 1;
    step();
    clrFlags = 0;
    #3 chk("overrun_clr", overrun, 0);
    fir_hold = 1;
    n0 = launches;
    step();
    drive(1, DW'($urandom)); step();
    drive(1, DW'($urandom)); step();
    drive(0, 0);
    repeat (20) step();
    chk("overrun_set", overrun, 1);
    chk("launches_in_hold", launches - n0, 1);
    fir_hold = 0;
    repeat (12) step();
    chk("launches_after_done", launches - n0, 2);

    fir_hold = 1;
    n0 = launches;
    drive(1, 16'h00aa); step(); drive(0, 0);
    wait_launches(n0 + 1, 20);
    for (int v = 1; v <= 4; v++) begin
      drive(1, DW'(v));
      step();
    end
    drive(1, 16'd5);
    chk("full_in_ready", inReady, 0);
    step();
    drive(0, 0);
    chk("full_count", 32'(dut.u_fifo.count), 4);
    fir_hold = 0;
    wait_launches(n0 + 5, 40);
    chk("full_launches", launches - n0, 5);
    for (int i = 0; i < 4; i++) chk("full_order", got[got.size() - 4 + i], i + 1);
    repeat (4) step();

    fir_hold = 1;
    n0 = launches;
    drive(1, DW'($urandom)); step(); drive(0, 0);
    wait_launches(n0 + 1, 20);
    for (int i = 0; i < 3; i++) begin
      drive(1, DW'($urandom));
      step();
    end
    drive(0, 0);
    chk("busy_count", 32'(dut.u_fifo.count), 3);
    #1 resetN = 0;
    #1;
    chk("arst_fir_start", firStart, 0);
    chk("arst_fir_data", firData, 0);
    chk("arst_tick", tick, 0);
    chk("arst_underflow", underflow, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_in_ready", inReady, 1);
    q.delete();
    fir_hold = 0;
    step();
    step();
    resetN = 1;
    #3;
    chk("post_rst_count", 32'(dut.u_fifo.count), 0);
    chk("post_rst_in_ready", inReady, 1);
    n0 = launches;
    repeat (30) step();
    chk("post_rst_no_launch", launches - n0, 0);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
